mem_port_ctrl: RTL

Shares the single-ported `Memory32` byte-addressed memory between the instruction-fetch requester and the load/store requester. It arbitrates round-robin between them, sequences accesses into read, write or read-modify-write cycles, and returns load data sign- or zero-extended. Sub-word stores need read-modify-write because `Memory32` always writes 4 bytes. The block sits between the CPU core and `Memory32`; its `mem_*` ports connect directly to the memory ports.

---
 rtl/mem_ctrl_pkg.sv | 43 ++++
 rtl/load_ext.sv | 21 ++
 rtl/mem_port_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the Memory32 port controller:
// access sizes, FSM states, requester identities and the store merge.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      RMW   = 2'd2,
      WRITE = 2'd3
   } state_t;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } owner_t;

   // Encoding 2'b11 is accepted on the bus and behaves as a full word.
   function automatic size_t decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   decode_size = BYTE;
         2'b01:   decode_size = HALF;
         default: decode_size = WORD;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                               input logic [31:0] new_data,
                                               input size_t       size);
      merge_store = old_word;
      case (size)
         BYTE:    merge_store[7:0]  = new_data[7:0];
         HALF:    merge_store[15:0] = new_data[15:0];
         default: merge_store       = new_data;
      endcase
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load-data extractor: selects the low byte/half/word of the raw memory
// word and sign- or zero-extends it to 32 bits.
module load_ext
   import mem_ctrl_pkg::*;
(
   input  size_t       size,
   input  logic        is_unsigned,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (size)
         BYTE:    ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
         HALF:    ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// Shares one Memory32 port between instruction fetch and load/store,
// round-robin arbitrated, with read-modify-write for sub-word stores.
module mem_port_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   // Handshake: a requester holds req with a stable payload until it sees
   // gnt; the payload is sampled in that grant cycle, and grants only
   // happen in IDLE.
   state_t      state_q, state_d;
   owner_t      prio_q, prio_d;
   owner_t      owner_q, owner_d;
   size_t       size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] raddr_q, raddr_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;

   size_t       req_size;
   logic        grant_i;
   logic        grant_d;

   assign req_size = decode_size(d_size);

   assign grant_i = (state_q == IDLE) & ~rst & i_req & (~d_req | (prio_q == INSTR));
   assign grant_d = (state_q == IDLE) & ~rst & d_req & (~i_req | (prio_q == DATA));

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      owner_d   = owner_q;
      size_d    = size_q;
      uns_d     = uns_q;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      i_gnt     = grant_i;
      d_gnt     = grant_d;
      i_rvalid  = 1'b0;
      d_done    = 1'b0;
      mem_we    = 1'b0;
      mem_raddr = raddr_q;

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               mem_raddr = i_addr;
               raddr_d   = i_addr;
               owner_d   = INSTR;
               prio_d    = DATA;
               state_d   = READ;
            end else if (grant_d) begin
               owner_d = DATA;
               prio_d  = INSTR;
               if (!d_we) begin
                  mem_raddr = d_addr;
                  raddr_d   = d_addr;
                  size_d    = req_size;
                  uns_d     = d_unsigned;
                  state_d   = READ;
               end else begin
                  waddr_d = d_addr;
                  wdata_d = d_wdata;
                  if (req_size == WORD) begin
                     state_d = WRITE;
                  end else begin
                     // Memory32 always writes four bytes, so fetch the old word first.
                     mem_raddr = d_addr;
                     raddr_d   = d_addr;
                     size_d    = req_size;
                     state_d   = RMW;
                  end
               end
            end
         end
         READ: begin
            i_rvalid = (owner_q == INSTR);
            d_done   = (owner_q == DATA);
            state_d  = IDLE;
         end
         RMW: begin
            wdata_d = merge_store(mem_rdata, wdata_q, size_q);
            state_d = WRITE;
         end
         WRITE: begin
            mem_we  = 1'b1;
            d_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= DATA;
         owner_q <= INSTR;
         size_q  <= BYTE;
         uns_q   <= 1'b0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = mem_rdata;

   load_ext u_load_ext (
      .size        (size_q),
      .is_unsigned (uns_q),
      .raw         (mem_rdata),
      .ext         (d_rdata)
   );

endmodule
